// File: rtl/sd_ctrl_pkg.sv
// Shared definitions for the SD read scheduler.
//   sd_state_e  : scheduler FSM encoding
//   sd_job_t    : latched job context (current sector, sectors left, owner)
//   SEC_BYTES   : bytes the engine delivers per sector
//   TIMEOUT_CYC_DEF / MAX_SECS_DEF : default parameter values
//   cnt_illegal : sector counts that must be rejected at grant
package sd_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_FIN   = 3'd4
  } sd_state_e;

  localparam int SEC_BYTES       = 512;
  localparam int TIMEOUT_CYC_DEF = 1048576;
  localparam int MAX_SECS_DEF    = 65535;

  typedef struct packed {
    logic [31:0] sec;
    logic [15:0] rem;
    logic        id;
  } sd_job_t;

  // Zero-length jobs and jobs above the configured maximum are refused.
  function automatic logic cnt_illegal(input logic [15:0] cnt, input int max_secs);
    return (cnt == 16'd0) || ({16'd0, cnt} > 32'(max_secs));
  endfunction

endpackage

// File: rtl/sd_rr_arb.sv
// 2-way round-robin arbiter with a last-winner pointer.
//   SD_clk, init : clock, synchronous active-low reset
//   i_req0/1     : requests
//   i_en         : grant is being taken this cycle (updates pointer)
//   o_gnt0/1     : one-hot combinational grant (both low if no request)
module sd_rr_arb (
  input  logic SD_clk,
  input  logic init,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_en,
  output logic o_gnt0,
  output logic o_gnt1
);

  // 1 = requester 1 won last, so requester 0 has priority on a tie.
  // Resetting to 1 makes requester 0 first after reset.
  logic r_last;

  assign o_gnt0 = i_req0 & (~i_req1 | r_last);
  assign o_gnt1 = i_req1 & (~i_req0 | ~r_last);

  always_ff @(posedge SD_clk) begin
    if (!init)                         r_last <= 1'b1;
    else if (i_en && (o_gnt0 || o_gnt1)) r_last <= o_gnt1;
  end

endmodule

// File: rtl/sd_read_sched.sv
// Two-requester job scheduler in front of an SD block-read engine.
// A job (start sector + count) is split into single-sector engine requests;
// engine bytes are forwarded tagged with the owning requester.
//   SD_clk, init           : clock, synchronous active-low reset
//   req*/sec*/cnt*/ack*    : job request handshake, per requester
//   done*_o, err_o         : job completion pulse, err valid with done
//   rd_req_o, rd_sec_o     : engine request / sector
//   rd_done_i              : engine sector-complete level
//   byte_i, byte_vld_i     : engine data in
//   byte_o, byte_vld_o, byte_id_o : forwarded data + owner
//   busy_o                 : FSM not idle
module sd_read_sched
  import sd_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int MAX_SECS    = MAX_SECS_DEF
) (
  input  logic        SD_clk,
  input  logic        init,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [31:0] sec0_i,
  input  logic [31:0] sec1_i,
  input  logic [15:0] cnt0_i,
  input  logic [15:0] cnt1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic        err_o,
  output logic        rd_req_o,
  output logic [31:0] rd_sec_o,
  input  logic        rd_done_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_vld_i,
  output logic [7:0]  byte_o,
  output logic        byte_vld_o,
  output logic        byte_id_o,
  output logic        busy_o
);

  localparam int                TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam int                BC_W    = $clog2(SEC_BYTES) + 2;

  sd_state_e        r_state;
  sd_job_t          r_job;
  logic             r_iss2;       // second ISSUE cycle
  logic [TO_W-1:0]  r_to;
  logic [BC_W-1:0]  r_bcnt;
  logic             r_err_acc;    // sticky short/long-sector flag for this job
  logic             r_rd_done_q;
  logic             r_ack0, r_ack1, r_done0, r_done1, r_err, r_rd_req;
  logic [7:0]       r_byte;
  logic             r_byte_vld;

  logic             w_gnt0, w_gnt1;
  logic [31:0]      w_sec;
  logic [15:0]      w_cnt;
  logic             w_rd_rise;
  logic [BC_W-1:0]  w_bcnt_nxt;

  sd_rr_arb u_arb (
    .SD_clk (SD_clk),
    .init   (init),
    .i_req0 (req0_i),
    .i_req1 (req1_i),
    .i_en   (r_state == S_IDLE),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  assign w_sec      = w_gnt1 ? sec1_i : sec0_i;
  assign w_cnt      = w_gnt1 ? cnt1_i : cnt0_i;
  assign w_rd_rise  = rd_done_i & ~r_rd_done_q;
  // Includes a byte arriving on the same cycle as the rd_done rise.
  assign w_bcnt_nxt = r_bcnt + BC_W'(byte_vld_i);

  always_ff @(posedge SD_clk) begin
    if (!init) begin
      r_state     <= S_IDLE;
      r_job       <= '0;
      r_iss2      <= 1'b0;
      r_to        <= '0;
      r_bcnt      <= '0;
      r_err_acc   <= 1'b0;
      r_rd_done_q <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err       <= 1'b0;
      r_rd_req    <= 1'b0;
      r_byte      <= '0;
      r_byte_vld  <= 1'b0;
    end else begin
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err       <= 1'b0;
      r_rd_done_q <= rd_done_i;
      r_byte      <= byte_i;
      r_byte_vld  <= byte_vld_i && (r_state == S_WAIT);

      // done/err are set on the edge entering FIN so the pulse coincides
      // with the FIN cycle; defaults above clear it on the way out.
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_ack0    <= w_gnt0;
            r_ack1    <= w_gnt1;
            r_job.id  <= w_gnt1;
            r_job.sec <= w_sec;
            r_job.rem <= w_cnt;
            r_err_acc <= 1'b0;
            if (cnt_illegal(w_cnt, MAX_SECS)) begin
              r_done0 <= w_gnt0;
              r_done1 <= w_gnt1;
              r_err   <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_rd_req <= 1'b1;
              r_iss2   <= 1'b0;
              r_state  <= S_ISSUE;
            end
          end
        end

        // rd_req held two cycles so a negedge-sampling engine always sees it.
        S_ISSUE: begin
          r_to   <= '0;
          r_bcnt <= '0;
          if (!r_iss2) begin
            r_iss2 <= 1'b1;
          end else begin
            r_rd_req <= 1'b0;
            r_state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          r_to <= r_to + TO_W'(1);
          if (byte_vld_i) r_bcnt <= w_bcnt_nxt;
          if (w_rd_rise) begin
            if (w_bcnt_nxt != BC_W'(SEC_BYTES)) r_err_acc <= 1'b1;
            r_state <= S_NEXT;
          end else if (r_to == TO_LAST) begin
            r_done0 <= ~r_job.id;
            r_done1 <= r_job.id;
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end
        end

        S_NEXT: begin
          r_job.rem <= r_job.rem - 16'd1;
          if (r_job.rem == 16'd1) begin
            r_done0 <= ~r_job.id;
            r_done1 <= r_job.id;
            r_err   <= r_err_acc;
            r_state <= S_FIN;
          end else begin
            r_job.sec <= r_job.sec + 32'd1;
            r_rd_req  <= 1'b1;
            r_iss2    <= 1'b0;
            r_state   <= S_ISSUE;
          end
        end

        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack0_o     = r_ack0;
  assign ack1_o     = r_ack1;
  assign done0_o    = r_done0;
  assign done1_o    = r_done1;
  assign err_o      = r_err;
  assign rd_req_o   = r_rd_req;
  assign rd_sec_o   = r_job.sec;
  assign byte_o     = r_byte;
  assign byte_vld_o = r_byte_vld;
  assign byte_id_o  = r_job.id;
  assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_sd_read_sched.sv
// Bench for sd_read_sched: behavioural engine, auto-dropping requesters and a
// scoreboard of expected sectors / done pulses filled by each test task.
module tb_sd_read_sched;

  typedef struct packed { logic id; logic err; } done_t;

  logic SD_clk = 1'b0;
  logic init   = 1'b0;
  always #5 SD_clk = ~SD_clk;

  logic        req0_i = 0, req1_i = 0;
  logic [31:0] sec0_i = 0, sec1_i = 0;
  logic [15:0] cnt0_i = 0, cnt1_i = 0;
  logic        rd_done_i = 0, byte_vld_i = 0;
  logic [7:0]  byte_i = 0;
  logic        ack0_o, ack1_o, done0_o, done1_o, err_o, rd_req_o;
  logic [31:0] rd_sec_o;
  logic [7:0]  byte_o;
  logic        byte_vld_o, byte_id_o, busy_o;

  sd_read_sched #(.TIMEOUT_CYC(1024), .MAX_SECS(65535)) dut (
    .SD_clk(SD_clk), .init(init),
    .req0_i(req0_i), .req1_i(req1_i), .sec0_i(sec0_i), .sec1_i(sec1_i),
    .cnt0_i(cnt0_i), .cnt1_i(cnt1_i), .ack0_o(ack0_o), .ack1_o(ack1_o),
    .done0_o(done0_o), .done1_o(done1_o), .err_o(err_o),
    .rd_req_o(rd_req_o), .rd_sec_o(rd_sec_o), .rd_done_i(rd_done_i),
    .byte_i(byte_i), .byte_vld_i(byte_vld_i), .byte_o(byte_o),
    .byte_vld_o(byte_vld_o), .byte_id_o(byte_id_o), .busy_o(busy_o)
  );

  // Second instance with a short timeout; its engine never completes.
  logic        to_req0 = 0;
  logic        to_ack0, to_ack1, to_done0, to_done1, to_err, to_rd_req;
  logic [31:0] to_rd_sec;
  logic [7:0]  to_byte;
  logic        to_byte_vld, to_byte_id, to_busy;

  sd_read_sched #(.TIMEOUT_CYC(64), .MAX_SECS(65535)) dut_to (
    .SD_clk(SD_clk), .init(init),
    .req0_i(to_req0), .req1_i(1'b0), .sec0_i(32'h10), .sec1_i(32'h0),
    .cnt0_i(16'd1), .cnt1_i(16'd0), .ack0_o(to_ack0), .ack1_o(to_ack1),
    .done0_o(to_done0), .done1_o(to_done1), .err_o(to_err),
    .rd_req_o(to_rd_req), .rd_sec_o(to_rd_sec), .rd_done_i(1'b0),
    .byte_i(8'h00), .byte_vld_i(1'b0), .byte_o(to_byte),
    .byte_vld_o(to_byte_vld), .byte_id_o(to_byte_id), .busy_o(to_busy)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge SD_clk) cyc <= cyc + 1;

  logic [31:0] exp_sec[$];
  done_t       exp_done[$];
  logic        exp_id = 0;
  int n_bytes = 0, n_rdreq = 0, n_done = 0;
  int ack0_cyc = -1, ack1_cyc = -1, done0_cyc = -1, done1_cyc = -1;
  int eng_bytes = 512;

  function automatic done_t mk_done(input logic id, input logic err);
    done_t d; d.id = id; d.err = err; return d;
  endfunction

  // Engine model: restarts on rd_req, streams eng_bytes bytes, raises rd_done.
  initial begin : engine
    int  cnt;
    bit  act;
    cnt = 0; act = 0;
    forever begin
      @(negedge SD_clk);
      if (!init) begin
        act = 0; cnt = 0; rd_done_i = 0; byte_vld_i = 0;
      end else if (rd_req_o) begin
        act = 1; cnt = 0; rd_done_i = 0; byte_vld_i = 0;
      end else if (act) begin
        if (cnt < eng_bytes) begin
          byte_vld_i = 1; byte_i = 8'(cnt); cnt++;
        end else begin
          byte_vld_i = 0; rd_done_i = 1; act = 0;
        end
      end else byte_vld_i = 0;
    end
  end

  // Requesters hold their request until acknowledged.
  initial begin : requesters
    forever begin
      @(negedge SD_clk);
      if (ack0_o) req0_i = 0;
      if (ack1_o) req1_i = 0;
    end
  end

  // Scoreboard: sectors, byte forwarding, done pulses.
  initial begin : monitor
    logic        prev_req;
    logic [31:0] prev_sec, s;
    logic        want_id;
    int          fidx;
    done_t       d;
    prev_req = 0; prev_sec = 0; fidx = 0;
    forever begin
      @(negedge SD_clk);
      if (!init) begin
        prev_req = 0; fidx = 0;
      end else begin
        if (rd_req_o) n_rdreq++;
        if (rd_req_o && !prev_req) begin
          n_checks++;
          if (exp_sec.size() == 0) begin
            n_fail++; $display("FAIL sector_issue: rd_sec_o=%h issued, none expected", rd_sec_o);
          end else begin
            s = exp_sec.pop_front();
            if (rd_sec_o !== s) begin
              n_fail++; $display("FAIL sector_issue: rd_sec_o=%h expected %h", rd_sec_o, s);
            end
          end
          fidx = 0;
        end else if (rd_req_o && prev_req) begin
          n_checks++;
          if (rd_sec_o !== prev_sec) begin
            n_fail++; $display("FAIL sector_stable: rd_sec_o=%h expected %h", rd_sec_o, prev_sec);
          end
        end
        prev_req = rd_req_o; prev_sec = rd_sec_o;

        if (byte_vld_o) begin
          want_id = (exp_done.size() > 0) ? exp_done[0].id : exp_id;
          n_checks++;
          if (byte_id_o !== want_id || byte_o !== 8'(fidx)) begin
            n_fail++;
            $display("FAIL byte_fwd: id=%0d byte=%h expected id=%0d byte=%h", byte_id_o, byte_o, want_id, 8'(fidx));
          end
          fidx++; n_bytes++;
        end

        if (ack0_o) ack0_cyc = cyc;
        if (ack1_o) ack1_cyc = cyc;
        if (done0_o || done1_o) begin
          n_checks++; n_done++;
          if (done0_o) done0_cyc = cyc;
          if (done1_o) done1_cyc = cyc;
          if (exp_done.size() == 0) begin
            n_fail++; $display("FAIL done_pulse: done1/done0/err=%b%b%b, none expected", done1_o, done0_o, err_o);
          end else begin
            d = exp_done.pop_front();
            if ({done1_o, done0_o, err_o} !== {d.id, ~d.id, d.err}) begin
              n_fail++;
              $display("FAIL done_pulse: done1/done0/err=%b%b%b expected %b%b%b", done1_o, done0_o, err_o, d.id, ~d.id, d.err);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int bound, input string name);
    int k;
    for (k = 0; k < bound; k++) begin
      @(negedge SD_clk);
      if (!busy_o && !req0_i && !req1_i && exp_done.size() == 0) break;
    end
    if (k == bound) begin
      n_checks++; n_fail++;
      $display("FAIL %s: not idle after %0d cycles, busy=%0d pending_done=%0d", name, bound, busy_o, exp_done.size());
    end
  endtask

  task automatic do_reset();
    @(negedge SD_clk); init = 0;
    repeat (2) @(negedge SD_clk);
    init = 1;
  endtask

  task automatic test_reset();
    logic [48:0] outs;
    init = 0;
    repeat (3) @(negedge SD_clk);
    outs = {ack0_o, ack1_o, done0_o, done1_o, err_o, rd_req_o, rd_sec_o, byte_o, byte_vld_o, byte_id_o, busy_o};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    init = 1;
    repeat (2) @(negedge SD_clk);
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy_o=%b expected 0", busy_o); end
  endtask

  task automatic test_multi_sector();
    int b0, r0, d0;
    b0 = n_bytes; r0 = n_rdreq; d0 = n_done;
    exp_sec.push_back(32'h100); exp_sec.push_back(32'h101); exp_sec.push_back(32'h102);
    exp_done.push_back(mk_done(1'b0, 1'b0));
    @(negedge SD_clk); sec0_i = 32'h100; cnt0_i = 16'd3; req0_i = 1;
    wait_idle(3000, "multi_sector");
    n_checks++;
    if (n_bytes - b0 != 1536) begin n_fail++; $display("FAIL multi_bytes: got %0d expected 1536", n_bytes - b0); end
    n_checks++;
    if (n_rdreq - r0 != 6) begin n_fail++; $display("FAIL multi_rdreq_cycles: got %0d expected 6", n_rdreq - r0); end
    n_checks++;
    if (n_done - d0 != 1 || exp_sec.size() != 0) begin
      n_fail++; $display("FAIL multi_done: dones=%0d left_secs=%0d expected 1/0", n_done - d0, exp_sec.size());
    end
  endtask

  task automatic test_arb_pair();
    do_reset();
    ack0_cyc = -1; ack1_cyc = -1; done0_cyc = -1;
    exp_sec.push_back(32'h200); exp_sec.push_back(32'h300);
    exp_done.push_back(mk_done(1'b0, 1'b0)); exp_done.push_back(mk_done(1'b1, 1'b0));
    @(negedge SD_clk);
    sec0_i = 32'h200; cnt0_i = 1; req0_i = 1;
    sec1_i = 32'h300; cnt1_i = 1; req1_i = 1;
    wait_idle(3000, "arb_pair");
    n_checks++;
    if (!(ack0_cyc >= 0 && ack0_cyc < ack1_cyc)) begin
      n_fail++; $display("FAIL arb_pair_order: ack0@%0d ack1@%0d expected ack0 first", ack0_cyc, ack1_cyc);
    end
    n_checks++;
    if (!(done0_cyc >= 0 && done0_cyc < ack1_cyc)) begin
      n_fail++; $display("FAIL arb_pair_done_first: done0@%0d ack1@%0d expected done0 first", done0_cyc, ack1_cyc);
    end
  endtask

  task automatic test_pending();
    ack1_cyc = -1; done0_cyc = -1;
    exp_sec.push_back(32'h600); exp_sec.push_back(32'h700);
    exp_done.push_back(mk_done(1'b0, 1'b0)); exp_done.push_back(mk_done(1'b1, 1'b0));
    @(negedge SD_clk); sec0_i = 32'h600; cnt0_i = 1; req0_i = 1;
    repeat (20) @(negedge SD_clk);
    sec1_i = 32'h700; cnt1_i = 1; req1_i = 1;
    wait_idle(3000, "pending");
    n_checks++;
    if (!(done0_cyc >= 0 && ack1_cyc > done0_cyc)) begin
      n_fail++; $display("FAIL pending_hold: ack1@%0d done0@%0d expected ack1 after done0", ack1_cyc, done0_cyc);
    end
  endtask

  task automatic test_rr_alternate();
    exp_sec.push_back(32'h800);
    exp_done.push_back(mk_done(1'b0, 1'b0));
    @(negedge SD_clk); sec0_i = 32'h800; cnt0_i = 1; req0_i = 1;
    wait_idle(2000, "rr_first");
    ack0_cyc = -1; ack1_cyc = -1;
    exp_sec.push_back(32'h900); exp_sec.push_back(32'hA00);
    exp_done.push_back(mk_done(1'b1, 1'b0)); exp_done.push_back(mk_done(1'b0, 1'b0));
    @(negedge SD_clk);
    sec0_i = 32'hA00; cnt0_i = 1; req0_i = 1;
    sec1_i = 32'h900; cnt1_i = 1; req1_i = 1;
    wait_idle(3000, "rr_pair");
    n_checks++;
    if (!(ack1_cyc >= 0 && ack1_cyc < ack0_cyc)) begin
      n_fail++; $display("FAIL rr_alternate: ack1@%0d ack0@%0d expected ack1 first", ack1_cyc, ack0_cyc);
    end
  endtask

  task automatic test_zero_cnt();
    int r0;
    r0 = n_rdreq; ack1_cyc = -1; done1_cyc = -1;
    exp_done.push_back(mk_done(1'b1, 1'b1));
    @(negedge SD_clk); sec1_i = 32'h55; cnt1_i = 0; req1_i = 1;
    wait_idle(50, "zero_cnt");
    n_checks++;
    if (!(ack1_cyc >= 0 && done1_cyc >= ack1_cyc && done1_cyc - ack1_cyc <= 2)) begin
      n_fail++; $display("FAIL zero_cnt_timing: ack1@%0d done1@%0d expected done within 2", ack1_cyc, done1_cyc);
    end
    n_checks++;
    if (n_rdreq != r0) begin n_fail++; $display("FAIL zero_cnt_rdreq: %0d rd_req cycles, expected 0", n_rdreq - r0); end
  endtask

  task automatic test_wrap();
    exp_sec.push_back(32'hFFFFFFFF); exp_sec.push_back(32'h00000000);
    exp_done.push_back(mk_done(1'b0, 1'b0));
    @(negedge SD_clk); sec0_i = 32'hFFFFFFFF; cnt0_i = 2; req0_i = 1;
    wait_idle(3000, "wrap");
    n_checks++;
    if (exp_sec.size() != 0) begin n_fail++; $display("FAIL wrap_sectors: %0d sectors not issued, expected 0", exp_sec.size()); end
  endtask

  task automatic test_short_sector();
    int b0;
    b0 = n_bytes; eng_bytes = 500;
    exp_sec.push_back(32'hB00); exp_sec.push_back(32'hB01);
    exp_done.push_back(mk_done(1'b0, 1'b1));
    @(negedge SD_clk); sec0_i = 32'hB00; cnt0_i = 2; req0_i = 1;
    wait_idle(3000, "short_sector");
    eng_bytes = 512;
    n_checks++;
    if (n_bytes - b0 != 1000 || exp_sec.size() != 0) begin
      n_fail++; $display("FAIL short_sector_complete: bytes=%0d left_secs=%0d expected 1000/0", n_bytes - b0, exp_sec.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0, k;
    logic [48:0] outs;
    exp_id = 0;
    exp_sec.push_back(32'h400);
    @(negedge SD_clk); sec0_i = 32'h400; cnt0_i = 4; req0_i = 1;
    for (k = 0; k < 100 && exp_sec.size() != 0; k++) @(negedge SD_clk);
    repeat (100) @(negedge SD_clk);
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_mid_busy: busy_o=%b expected 1", busy_o); end
    d0 = n_done;
    init = 0;
    @(negedge SD_clk);
    outs = {ack0_o, ack1_o, done0_o, done1_o, err_o, rd_req_o, rd_sec_o, byte_o, byte_vld_o, byte_id_o, busy_o};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_mid_outputs: got %h expected 0", outs); end
    init = 1;
    repeat (5) @(negedge SD_clk);
    n_checks++;
    if (n_done != d0) begin n_fail++; $display("FAIL reset_mid_no_done: %0d done pulses, expected 0", n_done - d0); end
    exp_sec.push_back(32'h500);
    exp_done.push_back(mk_done(1'b1, 1'b0));
    @(negedge SD_clk); sec1_i = 32'h500; cnt1_i = 1; req1_i = 1;
    wait_idle(2000, "reset_mid_next");
    n_checks++;
    if (n_done != d0 + 1 || exp_sec.size() != 0) begin
      n_fail++; $display("FAIL reset_mid_next_job: dones=%0d left_secs=%0d expected 1/0", n_done - d0, exp_sec.size());
    end
  endtask

  task automatic test_timeout();
    int  c0, c1, rq, k;
    logic prev, e;
    c0 = -1; c1 = -1; rq = 0; prev = 0; e = 0;
    @(negedge SD_clk); to_req0 = 1;
    for (k = 0; k < 300; k++) begin
      @(negedge SD_clk);
      if (to_ack0) to_req0 = 0;
      if (to_rd_req) rq++;
      if (prev && !to_rd_req && c0 < 0) c0 = cyc;
      prev = to_rd_req;
      if (to_done0) begin c1 = cyc; e = to_err; break; end
    end
    n_checks++;
    if (c0 < 0 || c1 - c0 != 64) begin
      n_fail++; $display("FAIL timeout_latency: done %0d cycles into WAIT, expected 64", c1 - c0);
    end
    n_checks++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL timeout_err: err_o=%b expected 1", e); end
    n_checks++;
    if (rq != 2) begin n_fail++; $display("FAIL timeout_rdreq_cycles: got %0d expected 2", rq); end
    @(negedge SD_clk);
    n_checks++;
    if (to_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: busy_o=%b expected 0", to_busy); end
  endtask

  initial begin
    test_reset();
    test_multi_sector();
    test_arb_pair();
    test_pending();
    test_rr_alternate();
    test_zero_cnt();
    test_wrap();
    test_short_sector();
    test_reset_mid();
    test_timeout();
    repeat (5) @(negedge SD_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_read_sched.md
SD_READ_SCHED -- requirements
Module: sd_read_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1048576, SD_clk cycles allowed per sector before error.
REQ-002 SHALL have parameter MAX_SECS, default 65535, max sectors per job (width of sec_cnt fixed at 16).
REQ-003 SD_clk  in  1  sole clock; all logic on posedge SD_clk.
REQ-004 init  in  1  reset, synchronous, active-low.
REQ-005 req0_i, req1_i  in  1 each  job request from requester 0/1, level, held until ack.
REQ-006 sec0_i, sec1_i  in  32 each  start sector of job.
REQ-007 cnt0_i, cnt1_i  in  16 each  sector count of job; 0 = illegal.
REQ-008 ack0_o, ack1_o  out  1 each  one-cycle pulse: job accepted, inputs captured.
REQ-009 done0_o, done1_o  out  1 each  one-cycle pulse: job finished (ok or error).
REQ-010 err_o  out  1  valid with done pulse: 1 = timeout or zero-count job.
REQ-011 rd_req_o  out  1  to block-read engine read_req.
REQ-012 rd_sec_o  out  32  to block-read engine sec.
REQ-013 rd_done_i  in  1  engine read_o (level; rises at sector end, cleared on next request).
REQ-014 byte_i  in  8  engine data; byte_vld_i  in  1  engine byte valid.
REQ-015 byte_o  out  8, byte_vld_o  out  1, byte_id_o  out  1  forwarded data tagged with owning requester.
REQ-016 busy_o  out  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT, NEXT, FIN.
REQ-018 IDLE: if any req, SHALL grant per round-robin (single request wins; both high -> requester not granted last; after reset requester 0 first), pulse ack, latch sec/cnt/id, -> ISSUE next cycle.
REQ-019 Zero cnt at grant SHALL go IDLE->FIN with err_o=1, no engine request.
REQ-020 ISSUE: rd_req_o=1 for exactly 2 cycles (covers engine negedge sampling), rd_sec_o=current sector, timeout counter cleared, -> WAIT.
REQ-021 WAIT: rising edge of rd_done_i (registered prior value 0, current 1) -> NEXT; counter reaching TIMEOUT_CYC-1 -> FIN with err_o=1.
REQ-022 NEXT: remaining-1; if 0 -> FIN, else current sector+1 (32-bit wrap 0xFFFFFFFF->0 permitted) -> ISSUE.
REQ-023 FIN: pulse done of owning requester for 1 cycle with err_o, -> IDLE; new grant no earlier than the following cycle.
REQ-024 byte_o/byte_vld_o SHALL be byte_i/byte_vld_i registered one cycle; byte_id_o=latched id; byte_vld_o forced 0 outside WAIT.
REQ-025 Per-sector byte counter SHALL count byte_vld_i in WAIT; rd_done rise with count != 512 SHALL set err_o at job end (job still completes all sectors).
REQ-026 Requests arriving while busy SHALL be held pending; no ack until IDLE.
REQ-027 rd_sec_o stable whenever rd_req_o=1; rd_req_o=0 in all other states.

Reset
REQ-028 With init=0 at posedge: state IDLE, all outputs 0, rr pointer -> requester 0, counters 0.
REQ-029 Reset mid-job SHALL abort silently (no done pulse); engine side reset by same init.

Structure
REQ-030 Package sd_ctrl_pkg SHALL hold state encoding, SEC_BYTES=512, default TIMEOUT_CYC.
REQ-031 One sub-module sd_rr_arb: 2-way round-robin grant with last-winner pointer.

Verification
REQ-032 req0, sec=0x100, cnt=3 -> rd_sec_o 0x100,0x101,0x102; 1536 byte_vld_o with id 0; one done0_o, err_o=0.
REQ-033 req0,req1 same cycle after reset, cnt=1 each -> ack0 first, then ack1; done0 precedes ack1.
REQ-034 Engine never raises rd_done, TIMEOUT_CYC=64 -> done pulse 64 cycles into WAIT, err_o=1, back to IDLE.
REQ-035 cnt1=0 -> ack1, done1 within 2 cycles, err_o=1, rd_req_o never asserted.
REQ-036 sec=0xFFFFFFFF, cnt=2 -> second rd_sec_o=0x00000000.
REQ-037 init low mid-sector of cnt=4 job -> all outputs 0 next cycle, no done, next req granted normally.
